// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// operation-select constants.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic input_carry,
  output logic sum,
  output logic output_carry
);

  always_comb begin
    sum          = a ^ b ^ input_carry;
    output_carry = (a & b) | (a & input_carry) | (b & input_carry);
  end

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial two's-complement adder/subtractor: one operand bit per clock,
// LSB first, under a start/busy/done handshake.
module serial_adder_subtractor
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             input_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             output_carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH:0]   res_shift;

  full_adder_cell u_fa (
    .a            (a_sr[0]),
    .b            (b_sr[0]),
    .input_carry  (carry_q),
    .sum          (fa_sum),
    .output_carry (fa_cout)
  );

  always_comb begin
    last_bit  = (cnt == CW'(WIDTH - 1));
    res_shift = {fa_sum, res_sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Results are published on the final RUN edge itself, so the pre-update
  // carry_q is the carry into the MSB and no separate register is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      carry_q      <= 1'b0;
      cnt          <= '0;
      sum          <= '0;
      output_carry <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= (mode == MODE_SUB) ? ~b : b;
            carry_q <= input_carry ^ (mode == MODE_SUB);
            cnt     <= '0;
          end
        end
        S_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_shift[WIDTH:1];
          carry_q <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            sum          <= res_shift[WIDTH:1];
            output_carry <= fa_cout;
            overflow     <= carry_q ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Scoreboard bench for serial_adder_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_adder_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8, mode8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, mode1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  serial_adder_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .input_carry(cin8), .busy(busy8), .done(done8), .sum(sum8),
    .output_carry(cout8), .overflow(ovf8)
  );

  serial_adder_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .input_carry(cin1), .busy(busy1), .done(done1), .sum(sum1),
    .output_carry(cout1), .overflow(ovf1)
  );

  typedef struct {
    string      name;
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT raises done.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      chk("busy8_with_done", {31'b0, busy8}, 0);
      if (q8.size() == 0) chk("unexpected_done8", {31'b0, done8}, 0);
      else begin
        e8 = q8.pop_front();
        chk({e8.name, "_sum"},  {24'b0, sum8}, {24'b0, e8.s});
        chk({e8.name, "_cout"}, {31'b0, cout8}, {31'b0, e8.c});
        chk({e8.name, "_ovf"},  {31'b0, ovf8},  {31'b0, e8.v});
      end
    end
    if (done1 === 1'b1) begin
      chk("busy1_with_done", {31'b0, busy1}, 0);
      if (q1.size() == 0) chk("unexpected_done1", {31'b0, done1}, 0);
      else begin
        e1 = q1.pop_front();
        chk({e1.name, "_sum"},  {31'b0, sum1},  {24'b0, e1.s});
        chk({e1.name, "_cout"}, {31'b0, cout1}, {31'b0, e1.c});
        chk({e1.name, "_ovf"},  {31'b0, ovf1},  {31'b0, e1.v});
      end
    end
  end

  // Called at the negedge following edge k0 after the load edge.
  task automatic wait_done8(input string name, input int k0);
    int k  = k0;
    int nb = k0;
    while (done8 !== 1'b1 && k < 40) begin
      if (busy8 === 1'b1) nb++;
      k++;
      @(negedge clk);
    end
    chk({name, "_latency"}, k, 8);
    chk({name, "_busy_cycles"}, nb, 8);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'b0, done8}, 0);
  endtask

  task automatic op8(input string name, input logic m, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es, input logic ec, input logic ev);
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = a; b8 = b; cin8 = c;
    q8.push_back('{name, es, ec, ev});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; mode8 = ~m; a8 = ~a; b8 = ~b; cin8 = ~c;
    wait_done8(name, 0);
  endtask

  task automatic op1(input string name, input logic a, input logic b, input logic c,
                     input logic es, input logic ec);
    int k = 0;
    @(negedge clk);
    start1 = 1'b1; mode1 = 1'b0; a1 = a; b1 = b; cin1 = c;
    q1.push_back('{name, {7'b0, es}, ec, c ^ ec});
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
    while (done1 !== 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk({name, "_latency"}, k, 1);
    @(negedge clk);
  endtask

  // {a, b, cin, sum, cout}
  logic [4:0] tv1 [8] = '{5'b000_00, 5'b001_10, 5'b010_10, 5'b011_01,
                          5'b100_10, 5'b101_01, 5'b110_01, 5'b111_11};

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    reset = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; mode1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", {31'b0, busy8}, 0);
    chk("rst_done8", {31'b0, done8}, 0);
    chk("rst_sum8",  {24'b0, sum8}, 0);
    chk("rst_cout8", {31'b0, cout8}, 0);
    chk("rst_ovf8",  {31'b0, ovf8}, 0);
    chk("rst_busy1", {31'b0, busy1}, 0);
    reset = 1'b0;

    op8("add_35_1a",  1'b0, 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0);
    op8("add_ff_01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01",  1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_0f_01c", 1'b0, 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0);
    op8("sub_10_20",  1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
    op8("sub_05_03b", 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0);
    op8("sub_80_01",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Reset on the 4th RUN cycle: outputs clear at once, no done follows.
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h35; b8 = 8'h1A; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", {31'b0, busy8}, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy8}, 0);
    chk("abort_done", {31'b0, done8}, 0);
    chk("abort_sum",  {24'b0, sum8}, 0);
    chk("abort_cout", {31'b0, cout8}, 0);
    chk("abort_ovf",  {31'b0, ovf8}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);

    // Fresh start; a second start and operand changes mid-RUN are ignored.
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h35; b8 = 8'h1A; cin8 = 1'b0;
    q8.push_back('{"ignore_restart", 8'h4F, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("ignore_restart", 3);

    foreach (tv1[i]) begin
      logic [4:0] v;
      v = tv1[i];
      op1($sformatf("w1_%0d%0d%0d", v[4], v[3], v[2]), v[4], v[3], v[2], v[1], v[0]);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard8_empty", q8.size(), 0);
    chk("scoreboard1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
